// File: rtl/conv_stream_controller.sv
// conv_stream_controller: sequencer streaming a zero-padded multi-channel image through a KxK filter datapath
module conv_stream_controller #(
  parameter int ADDR_WIDTH   = 18,
  parameter int KERNEL_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 480,
  parameter int IMAGE_HEIGHT = 360,
  parameter int CHANNELS     = 1,
  parameter int MEM_LATENCY  = 1,
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start_pulse,
  input  logic                  i_abort,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_finish_pulse,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_ren,
  output logic                  o_load_pixel,
  output logic                  o_init,
  output logic                  o_filter_en,
  output logic                  o_shift,
  output logic                  o_filtered_wstb,
  output logic [ADDR_WIDTH-1:0] o_filtered_addr,
  output logic [CH_W-1:0]       o_channel
);
  localparam logic [2:0] IDLE = 3'd0, INIT_BUF = 3'd1, WAIT = 3'd2, FILTER = 3'd3,
                         SHIFT = 3'd4, LOAD_ROW = 3'd5, NEXT_CH = 3'd6, DONE = 3'd7;
  localparam int ZP_W = IMAGE_WIDTH + KERNEL_SIZE - 1;
  localparam int CW = $clog2(KERNEL_SIZE * ZP_W + 1);
  localparam int RW = IMAGE_HEIGHT > 1 ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] INIT_LAST = CW'(KERNEL_SIZE * ZP_W - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(ZP_W - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_LATENCY - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  logic [2:0] state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] row;
  logic [MEM_LATENCY-1:0] dly;
  logic rd_last;
  always_comb begin
    o_busy          = state != IDLE;
    o_finish_pulse  = state == DONE;
    o_mem_ren       = state == INIT_BUF || state == LOAD_ROW;
    o_load_pixel    = dly[MEM_LATENCY-1];
    o_init          = (state == IDLE && i_nrst && i_start_pulse && !i_abort) || state == NEXT_CH;
    o_filter_en     = state == FILTER && i_out_ready;
    o_filtered_wstb = o_filter_en;
    o_shift         = state == SHIFT;
    rd_last         = cnt == (state == INIT_BUF ? INIT_LAST : ROW_LAST);
  end
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state           <= IDLE;
      cnt             <= '0;
      row             <= '0;
      dly             <= '0;
      o_channel       <= '0;
      o_mem_addr      <= '0;
      o_filtered_addr <= '0;
    end else begin
      // flushing on abort keeps already-issued reads from surfacing as loads
      dly <= i_abort ? '0 : MEM_LATENCY'({dly, o_mem_ren});
      if (i_abort) state <= IDLE;
      else case (state)
        IDLE: if (i_start_pulse) begin
          state           <= INIT_BUF;
          cnt             <= '0;
          row             <= '0;
          o_channel       <= '0;
          o_mem_addr      <= '0;
          o_filtered_addr <= '0;
        end
        INIT_BUF, LOAD_ROW: begin
          o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
          cnt        <= rd_last ? '0 : cnt + CW'(1);
          state      <= rd_last ? WAIT : state;
        end
        WAIT: begin
          cnt   <= cnt == WAIT_LAST ? '0 : cnt + CW'(1);
          state <= cnt == WAIT_LAST ? FILTER : WAIT;
        end
        FILTER: if (i_out_ready) begin
          o_filtered_addr <= o_filtered_addr + ADDR_WIDTH'(1);
          cnt             <= cnt == COL_LAST ? '0 : cnt + CW'(1);
          if (cnt == COL_LAST) begin
            row   <= row != ROW_MAX ? row + RW'(1) : row;
            state <= row != ROW_MAX ? SHIFT : o_channel != CH_LAST ? NEXT_CH : DONE;
          end
        end
        SHIFT: state <= LOAD_ROW;
        NEXT_CH: begin
          o_channel <= o_channel + CH_W'(1);
          row       <= '0;
          state     <= INIT_BUF;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
